alu_seq: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle datapath ALU: keeps AND/OR/PASS/ADD/SUB with flag generation, adds iterative MUL (low N bits) and UDIV (shift-subtract).
- Adds a valid/ready operand handshake, a held result handshake and an architectural NZCV flags register updated only by flag-setting ops.
- Sits in the execute stage; the pipeline stalls on in_ready=0 or out_valid=0.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_iter_muldiv.sv | 97 +++++++++
 rtl/alu_seq.sv | 146 ++++++++++++++
 tb/tb_alu_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag layout for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_ADD   = 4'b0010;  // bit3 selects flag update
    localparam logic [3:0] OP_SUB   = 4'b0110;  // bit3 selects flag update
    localparam logic [3:0] OP_MUL   = 4'b0011;
    localparam logic [3:0] OP_UDIV  = 4'b0100;

    localparam int unsigned FLAG_BIT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative engine: shift-add multiply (low N bits) and restoring unsigned divide.
module alu_iter_muldiv #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,      // 0 = MUL, 1 = UDIV
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,      // last step happens on the coming edge
    output logic [N-1:0] res,
    output logic         dbz
);

    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned NW    = N + 1;

    // x: multiplicand (MUL) or dividend/quotient shifter (UDIV)
    // y: multiplier (MUL) or divisor (UDIV)
    // acc: product (MUL) or partial remainder (UDIV)
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             dbz_q, dbz_d;
    logic [N-1:0]     x_q, x_d;
    logic [N-1:0]     y_q, y_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [NW-1:0]    rem_sh;
    logic [NW-1:0]    rem_sub;

    // Operand load on start, then one iteration per cycle while busy
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dbz_d   = dbz_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        rem_sh  = {acc_q, x_q[N-1]};
        rem_sub = rem_sh - {1'b0, y_q};
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(N);
            mode_d = mode;
            dbz_d  = mode && (b == '0);
            x_d    = a;
            y_d    = b;
            acc_d  = '0;
        end else if (busy_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
            if (!mode_q) begin
                if (y_q[0]) begin
                    acc_d = acc_q + x_q;
                end
                x_d = x_q << 1;
                y_d = y_q >> 1;
            end else if (!rem_sub[N]) begin
                acc_d = rem_sub[N-1:0];
                x_d   = {x_q[N-2:0], 1'b1};
            end else begin
                acc_d = rem_sh[N-1:0];
                x_d   = {x_q[N-2:0], 1'b0};
            end
        end
    end

    // Engine state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
            dbz_q  <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            acc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            dbz_q  <= dbz_d;
            x_q    <= x_d;
            y_q    <= y_d;
            acc_q  <= acc_d;
        end
    end

    assign done = busy_q && (cnt_q == CNT_W'(1));
    assign dbz  = dbz_q;
    assign res  = dbz_q ? '0 : (mode_q ? x_q : acc_q);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU with operand/result handshakes and NZCV register.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         div_by_zero,
    output logic [3:0]   nzcv,
    output logic         flags_written
);

    localparam int unsigned NW = N + 1;

    state_t        state_q, state_d;
    logic [N-1:0]  result_q, result_d;
    logic          res_sel_q, res_sel_d;   // result comes from the iterative engine
    logic          dbz_q, dbz_d;
    nzcv_t         nzcv_q, nzcv_d;
    logic          fw_q, fw_d;
    logic          start_c;
    logic          mode_c;
    logic [NW-1:0] sum;
    logic [NW-1:0] diff;
    logic          it_done;
    logic [N-1:0]  it_res;
    logic          it_dbz;

    alu_iter_muldiv #(.N(N)) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (start_c),
        .mode  (mode_c),
        .a     (a),
        .b     (b),
        .done  (it_done),
        .res   (it_res),
        .dbz   (it_dbz)
    );

    // Next-state, single-cycle datapath and flag update
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        res_sel_d = res_sel_q;
        dbz_d     = dbz_q;
        nzcv_d    = nzcv_q;
        fw_d      = 1'b0;
        start_c   = 1'b0;
        mode_c    = 1'b0;
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} + {1'b0, ~b} + NW'(1);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dbz_d     = 1'b0;
                    res_sel_d = 1'b0;
                    state_d   = DONE;
                    if (ALUControl == OP_MUL || ALUControl == OP_UDIV) begin
                        start_c  = 1'b1;
                        mode_c   = (ALUControl == OP_UDIV);
                        state_d  = ITER;
                        result_d = '0;
                    end else if (ALUControl == OP_AND) begin
                        result_d = a & b;
                    end else if (ALUControl == OP_OR) begin
                        result_d = a | b;
                    end else if (ALUControl == OP_PASSB) begin
                        result_d = b;
                    end else if (ALUControl[2:0] == OP_ADD[2:0]) begin
                        result_d = sum[N-1:0];
                        if (ALUControl[FLAG_BIT]) begin
                            nzcv_d.n = sum[N-1];
                            nzcv_d.z = (sum[N-1:0] == '0);
                            nzcv_d.c = sum[N];
                            nzcv_d.v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
                            fw_d     = 1'b1;
                        end
                    end else if (ALUControl[2:0] == OP_SUB[2:0]) begin
                        result_d = diff[N-1:0];
                        if (ALUControl[FLAG_BIT]) begin
                            nzcv_d.n = diff[N-1];
                            nzcv_d.z = (diff[N-1:0] == '0);
                            nzcv_d.c = diff[N];
                            nzcv_d.v = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
                            fw_d     = 1'b1;
                        end
                    end else begin
                        result_d = '0;
                    end
                end
            end
            ITER: begin
                if (it_done) begin
                    state_d   = DONE;
                    res_sel_d = 1'b1;
                    dbz_d     = it_dbz;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Architectural state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            res_sel_q <= 1'b0;
            dbz_q     <= 1'b0;
            nzcv_q    <= '0;
            fw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            res_sel_q <= res_sel_d;
            dbz_q     <= dbz_d;
            nzcv_q    <= nzcv_d;
            fw_q      <= fw_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign result        = res_sel_q ? it_res : result_q;
    assign zero          = (result == '0);
    assign div_by_zero   = dbz_q;
    assign nzcv          = nzcv_q;
    assign flags_written = fw_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized scoreboard bench for alu_seq at N=64 and N=8.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] a, b;
    logic [3:0]  ctl;
    logic        out_ready;
    logic        sel;          // 0 drives the N=64 instance, 1 the N=8 instance
    logic        rand_rdy;

    logic        ir64, ov64, z64, dbz64, fw64;
    logic [63:0] res64;
    logic [3:0]  nz64;
    logic        ir8, ov8, z8, dbz8, fw8;
    logic [7:0]  res8;
    logic [3:0]  nz8;

    logic        ir_m, ov_m, z_m, dbz_m, fw_m;
    logic [63:0] res_m;
    logic [3:0]  nz_m;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        logic [3:0]  nzcv;
        logic        fw;
        int          lat;
        longint      t;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  mnz64, mnz8;
    logic        prev_v = 1'b0;
    logic [63:0] held;

    always #5 clk = ~clk;

    alu_seq #(.N(64)) u64 (
        .clk(clk), .reset(reset), .in_valid(in_valid && !sel), .in_ready(ir64),
        .a(a), .b(b), .ALUControl(ctl), .out_valid(ov64), .out_ready(out_ready),
        .result(res64), .zero(z64), .div_by_zero(dbz64), .nzcv(nz64),
        .flags_written(fw64)
    );

    alu_seq #(.N(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel), .in_ready(ir8),
        .a(a[7:0]), .b(b[7:0]), .ALUControl(ctl), .out_valid(ov8), .out_ready(out_ready),
        .result(res8), .zero(z8), .div_by_zero(dbz8), .nzcv(nz8),
        .flags_written(fw8)
    );

    assign ir_m  = sel ? ir8  : ir64;
    assign ov_m  = sel ? ov8  : ov64;
    assign z_m   = sel ? z8   : z64;
    assign dbz_m = sel ? dbz8 : dbz64;
    assign fw_m  = sel ? fw8  : fw64;
    assign nz_m  = sel ? nz8  : nz64;
    assign res_m = sel ? {56'd0, res8} : res64;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the opcode rules, at width w
    function automatic exp_t model(input logic [3:0] op, input logic [63:0] ai, input logic [63:0] bi,
                                   input int w, input logic [3:0] fl, input longint t);
        exp_t        e;
        logic [63:0] m, av, bv, r;
        logic [64:0] s;
        logic        sa, sb, sr, c, v, sub;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        av = ai & m;
        bv = bi & m;
        e.res = '0; e.dbz = 1'b0; e.fw = 1'b0; e.nzcv = fl; e.lat = 1; e.t = t;
        if (op == 4'b0011) begin
            e.res = (av * bv) & m;
            e.lat = w + 1;
        end else if (op == 4'b0100) begin
            e.lat = w + 1;
            if (bv == 0) e.dbz = 1'b1;
            else         e.res = av / bv;
        end else if (op == 4'b0000) begin
            e.res = av & bv;
        end else if (op == 4'b0001) begin
            e.res = av | bv;
        end else if (op == 4'b0111) begin
            e.res = bv;
        end else if (op[2:0] == 3'b010 || op[2:0] == 3'b110) begin
            sub = op[2];
            s = sub ? ({1'b0, av} + {1'b0, (~bv) & m} + 65'd1) : ({1'b0, av} + {1'b0, bv});
            r = s[63:0] & m;
            c = s[w];
            sa = av[w-1]; sb = bv[w-1]; sr = r[w-1];
            v = sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
            e.res = r;
            if (op[3]) begin
                e.fw = 1'b1;
                e.nzcv = {sr, (r == 0), c, v};
            end
        end
        return e;
    endfunction

    function automatic logic [63:0] rnd();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0080;
            4: return 64'h7FFF_FFFF_FFFF_FF7F;
            5: return 64'($urandom_range(0, 255));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Random consumer backpressure
    always @(negedge clk) begin
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on each new result, checks holding and flag pulses
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (ov_m && !prev_v) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result actual=%h required=none", res_m);
                end else begin
                    e = q.pop_front();
                    check("result", res_m, e.res);
                    check("zero", 64'(z_m), 64'(e.res == 0));
                    check("div_by_zero", 64'(dbz_m), 64'(e.dbz));
                    check("nzcv", 64'(nz_m), 64'(e.nzcv));
                    check("flags_written", 64'(fw_m), 64'(e.fw));
                    check("latency", 64'(($time - e.t) / 10), 64'(e.lat));
                    check("in_ready_in_done", 64'(ir_m), 64'd0);
                end
                held = res_m;
            end else if (ov_m) begin
                check("result_held", res_m, held);
                check("flags_written_held", 64'(fw_m), 64'd0);
            end else begin
                check("flags_written_idle", 64'(fw_m), 64'd0);
            end
        end
        prev_v = ov_m;
    end

    // Waits for IDLE, scrambling inputs meanwhile, then presents one operation
    task automatic issue(input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv);
        int  n = 0;
        bit  fin = 0;
        while (!fin) begin
            @(negedge clk);
            if (ir_m) begin
                a = av; b = bv; ctl = op; in_valid = 1'b1;
                if (sel) begin
                    q.push_back(model(op, av, bv, 8, mnz8, $time));
                    mnz8 = q[q.size()-1].nzcv;
                end else begin
                    q.push_back(model(op, av, bv, 64, mnz64, $time));
                    mnz64 = q[q.size()-1].nzcv;
                end
                @(posedge clk);
                fin = 1;
            end else begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                ctl = 4'($urandom_range(0, 15));
                in_valid = 1'($urandom_range(0, 1));
                n++;
                if (n > 600) begin
                    total++;
                    bad++;
                    $display("FAIL issue_timeout actual=busy required=in_ready");
                    fin = 1;
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!(q.size() == 0 && ir_m) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
        end
    endtask

    initial begin
        logic [3:0] op;
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; ctl = '0;
        out_ready = 1'b1; sel = 1'b0; rand_rdy = 1'b0;
        mnz64 = '0; mnz8 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst64_in_ready", 64'(ir64), 64'd1);
        check("rst64_out_valid", 64'(ov64), 64'd0);
        check("rst64_result", res64, 64'd0);
        check("rst64_nzcv", 64'(nz64), 64'd0);
        check("rst64_fw", 64'(fw64), 64'd0);
        check("rst64_dbz", 64'(dbz64), 64'd0);
        check("rst8_in_ready", 64'(ir8), 64'd1);
        check("rst8_out_valid", 64'(ov8), 64'd0);
        check("rst8_result", 64'(res8), 64'd0);
        check("rst8_nzcv", 64'(nz8), 64'd0);

        // N=64 directed then random
        issue(4'b1010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        issue(4'b1110, 64'd5, 64'd5);
        issue(4'b0110, 64'd0, 64'd1);
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) issue(4'($urandom_range(0, 15)), rnd(), rnd());
        drain();

        // N=8 directed then random
        sel = 1'b1;
        issue(4'b0011, 64'h0D, 64'h0B);
        issue(4'b0100, 64'hC8, 64'h07);
        issue(4'b0100, 64'hC8, 64'h00);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) op = ($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b0100;
            else                           op = 4'($urandom_range(0, 15));
            issue(op, rnd(), rnd());
        end
        drain();

        // Held result under backpressure, then release
        rand_rdy = 1'b0;
        out_ready = 1'b0;
        issue(4'b1010, 64'h7F, 64'h01);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(ov_m), 64'd1);
            check("bp_in_ready", 64'(ir_m), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 64'(ir_m), 64'd1);
        check("release_out_valid", 64'(ov_m), 64'd0);

        // Reset in the middle of a multiply
        issue(4'b0011, 64'h0D, 64'h0B);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_iter_in_ready", 64'(ir_m), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        q.delete();
        mnz8 = '0;
        mnz64 = '0;
        check("rst_mid_in_ready", 64'(ir_m), 64'd1);
        check("rst_mid_out_valid", 64'(ov_m), 64'd0);
        check("rst_mid_nzcv", 64'(nz_m), 64'd0);
        check("rst_mid_fw", 64'(fw_m), 64'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_out_valid", 64'(ov_m), 64'd0);
        check("post_rst_fw", 64'(fw_m), 64'd0);

        rand_rdy = 1'b1;
        for (int i = 0; i < 10; i++) issue(4'($urandom_range(0, 15)), rnd(), rnd());
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
